regfile_write_arbiter: RTL and testbench

//  Owns the single register-file write port. Shares it between pipeline writeback (WB) and a multi-cycle unit (MC: mul/div, late loads).

---
 rtl/pipeline_pkg.sv | 29 ++
 rtl/mc_result_fifo.sv | 57 +++++
 rtl/regfile_write_arbiter.sv | 167 ++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared widths and types for the register-file write path.
// Imported by the write arbiter and its MC result FIFO.
package pipeline_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;
    localparam int ENTRY_W    = REG_ADDR_W + XLEN;

    typedef enum logic {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] write_reg;
        logic [XLEN-1:0]       write_data;
    } wb_req_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] write_reg;
        logic [XLEN-1:0]       write_data;
    } mc_req_t;

    function automatic logic is_x0(input logic [REG_ADDR_W-1:0] r);
        return r == '0;
    endfunction

endpackage

// File: rtl/mc_result_fifo.sv
// Small FIFO holding multi-cycle unit results until they win the write port.
// Head entry is visible combinationally; DEPTH must be a power of two.
module mc_result_fifo
    import pipeline_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: WB has priority, MC results queue in a FIFO,
// a starvation guard forces one MC slot, and a pending scoreboard stalls decode.
module regfile_write_arbiter
    import pipeline_pkg::*;
#(
    parameter  int DEPTH        = 2,
    parameter  int STARVE_LIMIT = 4,
    localparam int CNT_W        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_write_reg,
    input  logic [XLEN-1:0]       wb_write_data,
    output logic                  wb_stall,
    input  logic                  mc_valid,
    input  logic [REG_ADDR_W-1:0] mc_write_reg,
    input  logic [XLEN-1:0]       mc_write_data,
    output logic                  mc_ready,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_reg,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    output logic                  dec_stall,
    output logic                  do_reg_write,
    output logic [REG_ADDR_W-1:0] do_write_reg,
    output logic [XLEN-1:0]       write_data,
    output logic                  dbg_state,
    output logic [CNT_W-1:0]      dbg_fifo_count
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t            state;
    arb_state_t            state_next;
    logic [STARVE_W-1:0]   starve_cnt;
    logic [STARVE_W-1:0]   starve_next;
    logic [NUM_REGS-1:0]   pending;
    logic [NUM_REGS-1:0]   pending_next;
    logic                  out_from_mc;

    wb_req_t               wb_in;
    mc_req_t               mc_in;
    mc_req_t               mc_head;
    logic [ENTRY_W-1:0]    fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_push;
    logic                  wb_req;
    logic                  grant_wb;
    logic                  grant_mc;
    logic                  mc_discard;

    assign wb_in   = '{write_reg: wb_write_reg, write_data: wb_write_data};
    assign mc_in   = '{write_reg: mc_write_reg, write_data: mc_write_data};
    assign mc_head = mc_req_t'(fifo_head);
    assign wb_req  = wb_reg_write & ~is_x0(wb_write_reg);

    // MC handshake: a result transfers on a cycle where mc_valid & mc_ready are both
    // high; mc_ready depends only on FIFO fullness, never on mc_valid.
    assign mc_ready  = ~fifo_full;
    assign fifo_push = mc_valid & mc_ready;

    mc_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (mc_in),
        .pop     (grant_mc),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign mc_discard     = is_x0(mc_head.write_reg);
    assign dbg_state      = (state == DRAIN);
    assign dbg_fifo_count = fifo_count;

    // Starvation is counted only while an MC result is actually waiting.
    always_comb begin
        state_next  = state;
        starve_next = starve_cnt;
        grant_wb    = 1'b0;
        grant_mc    = 1'b0;
        wb_stall    = 1'b0;
        case (state)
            NORMAL: begin
                if (wb_req) begin
                    grant_wb = 1'b1;
                    if (fifo_empty) begin
                        starve_next = '0;
                    end else begin
                        starve_next = starve_cnt + 1'b1;
                        if (starve_next == STARVE_W'(STARVE_LIMIT)) state_next = DRAIN;
                    end
                end else if (!fifo_empty) begin
                    grant_mc    = 1'b1;
                    starve_next = '0;
                end else begin
                    starve_next = '0;
                end
            end
            DRAIN: begin
                grant_mc    = 1'b1;
                wb_stall    = wb_req;
                starve_next = '0;
                state_next  = NORMAL;
            end
            default: begin
                state_next  = NORMAL;
                starve_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= NORMAL;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

    // A popped x0 result consumes its FIFO slot but never reaches the port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            do_reg_write <= 1'b0;
            do_write_reg <= '0;
            write_data   <= '0;
            out_from_mc  <= 1'b0;
        end else if (grant_wb) begin
            do_reg_write <= 1'b1;
            do_write_reg <= wb_in.write_reg;
            write_data   <= wb_in.write_data;
            out_from_mc  <= 1'b0;
        end else if (grant_mc && !mc_discard) begin
            do_reg_write <= 1'b1;
            do_write_reg <= mc_head.write_reg;
            write_data   <= mc_head.write_data;
            out_from_mc  <= 1'b1;
        end else begin
            do_reg_write <= 1'b0;
            out_from_mc  <= 1'b0;
        end
    end

    // Pending clears on the edge the register file commits the MC write; a new issue wins.
    always_comb begin
        pending_next = pending;
        if (do_reg_write && out_from_mc) pending_next[do_write_reg] = 1'b0;
        if (issue_valid) pending_next[issue_reg] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) pending <= '0;
        else        pending <= pending_next;
    end

    assign dec_stall = pending[dec_rs1] | pending[dec_rs2] | pending[dec_rd];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, multi-cycle corner sequences,
// and random traffic compared every cycle against a queue-based reference model.
module tb_regfile_write_arbiter;
    import pipeline_pkg::*;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;
    localparam int CNT_W        = $clog2(DEPTH) + 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  wb_reg_write = 1'b0;
    logic [REG_ADDR_W-1:0] wb_write_reg = '0;
    logic [XLEN-1:0]       wb_write_data = '0;
    logic                  wb_stall;
    logic                  mc_valid = 1'b0;
    logic [REG_ADDR_W-1:0] mc_write_reg = '0;
    logic [XLEN-1:0]       mc_write_data = '0;
    logic                  mc_ready;
    logic                  issue_valid = 1'b0;
    logic [REG_ADDR_W-1:0] issue_reg = '0;
    logic [REG_ADDR_W-1:0] dec_rs1 = '0;
    logic [REG_ADDR_W-1:0] dec_rs2 = '0;
    logic [REG_ADDR_W-1:0] dec_rd = '0;
    logic                  dec_stall;
    logic                  do_reg_write;
    logic [REG_ADDR_W-1:0] do_write_reg;
    logic [XLEN-1:0]       write_data;
    logic                  dbg_state;
    logic [CNT_W-1:0]      dbg_fifo_count;

    regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wb_reg_write   (wb_reg_write),
        .wb_write_reg   (wb_write_reg),
        .wb_write_data  (wb_write_data),
        .wb_stall       (wb_stall),
        .mc_valid       (mc_valid),
        .mc_write_reg   (mc_write_reg),
        .mc_write_data  (mc_write_data),
        .mc_ready       (mc_ready),
        .issue_valid    (issue_valid),
        .issue_reg      (issue_reg),
        .dec_rs1        (dec_rs1),
        .dec_rs2        (dec_rs2),
        .dec_rd         (dec_rd),
        .dec_stall      (dec_stall),
        .do_reg_write   (do_reg_write),
        .do_write_reg   (do_write_reg),
        .write_data     (write_data),
        .dbg_state      (dbg_state),
        .dbg_fifo_count (dbg_fifo_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [ENTRY_W-1:0]    m_q[$];
    bit                    m_pend[NUM_REGS];
    int                    m_starve;
    bit                    m_drain;
    bit                    m_we;
    bit                    m_from_mc;
    logic [REG_ADDR_W-1:0] m_reg;
    logic [XLEN-1:0]       m_data;

    task automatic model_step();
        int                 sz;
        bit                 wb_req;
        bit                 g_wb;
        bit                 g_mc;
        logic [ENTRY_W-1:0] h;
        if (!rst_n) begin
            m_q.delete();
            foreach (m_pend[r]) m_pend[r] = 1'b0;
            m_starve = 0; m_drain = 1'b0;
            m_we = 1'b0; m_from_mc = 1'b0; m_reg = '0; m_data = '0;
            return;
        end
        sz     = m_q.size();
        wb_req = wb_reg_write && (wb_write_reg != 0);
        g_wb   = 1'b0;
        g_mc   = 1'b0;
        if (m_drain)     g_mc = 1'b1;
        else if (wb_req) g_wb = 1'b1;
        else if (sz > 0) g_mc = 1'b1;
        if (m_we && m_from_mc) m_pend[m_reg] = 1'b0;
        if (issue_valid && issue_reg != 0) m_pend[issue_reg] = 1'b1;
        if (g_wb) begin
            m_we = 1'b1; m_from_mc = 1'b0; m_reg = wb_write_reg; m_data = wb_write_data;
        end else if (g_mc) begin
            h = m_q.pop_front();
            m_we      = (h[ENTRY_W-1:XLEN] != 0);
            m_from_mc = m_we;
            if (m_we) begin
                m_reg  = h[ENTRY_W-1:XLEN];
                m_data = h[XLEN-1:0];
            end
        end else begin
            m_we = 1'b0; m_from_mc = 1'b0;
        end
        if (m_drain) begin
            m_drain = 1'b0; m_starve = 0;
        end else if (g_wb && sz > 0) begin
            m_starve++;
            if (m_starve == STARVE_LIMIT) m_drain = 1'b1;
        end else begin
            m_starve = 0;
        end
        if (mc_valid && sz < DEPTH) m_q.push_back({mc_write_reg, mc_write_data});
    endtask

    task automatic model_compare();
        check("m.wb_stall", wb_stall, m_drain && wb_reg_write && wb_write_reg != 0);
        check("m.mc_ready", mc_ready, m_q.size() < DEPTH);
        check("m.dec_stall", dec_stall, m_pend[dec_rs1] | m_pend[dec_rs2] | m_pend[dec_rd]);
        check("m.do_reg_write", do_reg_write, m_we);
        check("m.fifo_count", dbg_fifo_count, m_q.size());
        check("m.drain", dbg_state, m_drain);
        if (m_we) begin
            check("m.do_write_reg", do_write_reg, m_reg);
            check("m.write_data", write_data, m_data);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic sample();
        @(negedge clk);
        model_compare();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        wb_reg_write = 1'b0; mc_valid = 1'b0; issue_valid = 1'b0;
        dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic                  wb_we;
        logic [REG_ADDR_W-1:0] wb_r;
        logic [XLEN-1:0]       wb_d;
        logic                  mc_v;
        logic [REG_ADDR_W-1:0] mc_r;
        logic [XLEN-1:0]       mc_d;
        logic                  iss;
        logic [REG_ADDR_W-1:0] iss_r;
        logic [REG_ADDR_W-1:0] dec;
        logic                  e_wbs;
        logic                  e_rdy;
        logic                  e_dec;
        logic                  e_we;
        logic [REG_ADDR_W-1:0] e_reg;
        logic [XLEN-1:0]       e_data;
    } vec_t;

    vec_t vt[14];
    logic [ENTRY_W-1:0] exp_q[$];

    initial begin
        logic                  stalled;
        logic [REG_ADDR_W-1:0] cur_reg;
        logic [XLEN-1:0]       cur_data;
        logic [REG_ADDR_W-1:0] held_reg;
        logic [XLEN-1:0]       held_data;
        int                    mc_idx;

        // WB x5, no MC: written on the next cycle only
        vt[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        vt[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
        vt[2]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        // issue x7, MC result lands two cycles after acceptance, stall clears the cycle after
        vt[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        vt[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0};
        vt[5]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0};
        vt[6]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0};
        vt[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h11};
        vt[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        // x0 on every path: nothing written, nothing pending
        vt[9]  = '{1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        vt[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        vt[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        vt[12] = '{1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        vt[13] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 32'h1};

        // ---------------- reset ----------------
        idle_inputs();
        rst_n = 1'b0;
        advance();
        advance();
        rst_n = 1'b1;
        sample();
        check("rst.do_reg_write", do_reg_write, 1'b0);
        check("rst.do_write_reg", do_write_reg, 5'd0);
        check("rst.write_data", write_data, 32'h0);
        check("rst.mc_ready", mc_ready, 1'b1);
        check("rst.wb_stall", wb_stall, 1'b0);
        check("rst.state", dbg_state, 1'b0);
        advance();

        // ---------------- table ----------------
        for (int k = 0; k < 14; k++) begin
            wb_reg_write = vt[k].wb_we; wb_write_reg = vt[k].wb_r; wb_write_data = vt[k].wb_d;
            mc_valid = vt[k].mc_v; mc_write_reg = vt[k].mc_r; mc_write_data = vt[k].mc_d;
            issue_valid = vt[k].iss; issue_reg = vt[k].iss_r;
            dec_rs1 = vt[k].dec; dec_rs2 = '0; dec_rd = '0;
            sample();
            check($sformatf("vec%0d.wb_stall", k), wb_stall, vt[k].e_wbs);
            check($sformatf("vec%0d.mc_ready", k), mc_ready, vt[k].e_rdy);
            check($sformatf("vec%0d.dec_stall", k), dec_stall, vt[k].e_dec);
            check($sformatf("vec%0d.do_reg_write", k), do_reg_write, vt[k].e_we);
            if (vt[k].e_we) begin
                check($sformatf("vec%0d.do_write_reg", k), do_write_reg, vt[k].e_reg);
                check($sformatf("vec%0d.write_data", k), write_data, vt[k].e_data);
            end
            advance();
        end
        idle_inputs();

        // ---------------- starvation guard: 4 WB grants, then one forced MC slot ----------------
        stalled = 1'b0; cur_reg = '0; cur_data = '0; held_reg = '0; held_data = '0;
        for (int i = 0; i < 10; i++) begin
            if (!stalled) begin
                cur_reg  = REG_ADDR_W'(10 + (i % 4));
                cur_data = 32'h3000_0000 + 32'(i);
            end
            wb_reg_write = 1'b1; wb_write_reg = cur_reg; wb_write_data = cur_data;
            mc_valid = (i == 0); mc_write_reg = 5'd9; mc_write_data = 32'h99;
            sample();
            check($sformatf("starve.wb_stall[%0d]", i), wb_stall, i == 5);
            if (i == 5) begin
                held_reg  = cur_reg;
                held_data = cur_data;
            end
            if (i == 6) begin
                check("starve.mc_we", do_reg_write, 1'b1);
                check("starve.mc_reg", do_write_reg, 5'd9);
                check("starve.mc_data", write_data, 32'h99);
            end
            if (i == 7) begin
                check("starve.held_we", do_reg_write, 1'b1);
                check("starve.held_reg", do_write_reg, held_reg);
                check("starve.held_data", write_data, held_data);
            end
            stalled = wb_stall;
            advance();
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin sample(); advance(); end

        // ---------------- FIFO backpressure: 3 MC results under continuous WB ----------------
        exp_q.delete();
        for (int j = 0; j < 3; j++) exp_q.push_back({REG_ADDR_W'(20 + j), 32'hA000_0000 + 32'(j)});
        mc_idx = 0; stalled = 1'b0;
        for (int i = 0; i < 45; i++) begin
            if (!stalled) begin
                cur_reg  = REG_ADDR_W'(1 + (i % 4));
                cur_data = 32'h4000_0000 + 32'(i);
            end
            wb_reg_write = (i < 40); wb_write_reg = cur_reg; wb_write_data = cur_data;
            mc_valid = (mc_idx < 3);
            mc_write_reg = REG_ADDR_W'(20 + mc_idx); mc_write_data = 32'hA000_0000 + 32'(mc_idx);
            sample();
            if (i == 2) check("fifo.mc_ready_full", mc_ready, 1'b0);
            if (do_reg_write && do_write_reg >= 5'd20 && do_write_reg <= 5'd22) begin
                if (exp_q.size() == 0) check("fifo.extra_write", do_write_reg, 5'd0);
                else check("fifo.order", {do_write_reg, write_data}, exp_q.pop_front());
            end
            if (mc_valid && mc_ready) mc_idx++;
            stalled = wb_stall;
            advance();
        end
        check("fifo.all_written", exp_q.size(), 0);
        idle_inputs();

        // ---------------- reset mid-operation ----------------
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            dec_rs1 = 5'd3; dec_rs2 = 5'd4;
            rst_n = !(i == 3);
            if (i < 4) begin
                wb_reg_write = 1'b1; wb_write_reg = 5'd1; wb_write_data = 32'h5000_0000 + 32'(i);
            end
            if (i == 0) begin issue_valid = 1'b1; issue_reg = 5'd3; mc_valid = 1'b1; mc_write_reg = 5'd3; mc_write_data = 32'h33; end
            if (i == 1) begin issue_valid = 1'b1; issue_reg = 5'd4; mc_valid = 1'b1; mc_write_reg = 5'd4; mc_write_data = 32'h44; end
            sample();
            if (i == 2) begin
                check("rstmid.full", mc_ready, 1'b0);
                check("rstmid.pending", dec_stall, 1'b1);
            end
            if (i == 4) begin
                check("rstmid.mc_ready", mc_ready, 1'b1);
                check("rstmid.dec_stall", dec_stall, 1'b0);
            end
            if (i >= 4) check($sformatf("rstmid.no_write[%0d]", i), do_reg_write, 1'b0);
            advance();
        end
        idle_inputs();

        // ---------------- random traffic against the model ----------------
        stalled = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if (!stalled) begin
                wb_reg_write  = ($urandom_range(0, 99) < 60);
                wb_write_reg  = REG_ADDR_W'($urandom_range(0, 7));
                wb_write_data = $urandom;
            end
            mc_valid      = ($urandom_range(0, 99) < 35);
            mc_write_reg  = REG_ADDR_W'($urandom_range(0, 7));
            mc_write_data = $urandom;
            issue_valid   = ($urandom_range(0, 99) < 25);
            issue_reg     = REG_ADDR_W'($urandom_range(0, 7));
            dec_rs1       = REG_ADDR_W'($urandom_range(0, 7));
            dec_rs2       = REG_ADDR_W'($urandom_range(0, 7));
            dec_rd        = REG_ADDR_W'($urandom_range(0, 7));
            sample();
            stalled = wb_stall;
            advance();
        end

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
